pq_host_sequencer: RTL and testbench

//  Host-side initiator for the BRAM tree priority queue: drives its i_wrt/i_read/i_data pins, reads o_data.

---
 rtl/pq_host_sequencer.sv | 156 +++++++++++++++
 tb/tb_pq_host_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pq_host_sequencer.sv
// Purpose: host-side initiator for the BRAM tree priority queue (ENQ / DEQ / REPLACE), tracks occupancy.
// Latency: accept at T, queue pulse at T+1, settle SETTLE_CYCLES, then ready (ENQ) or response (DEQ/REPLACE).
// Backpressure: o_req_ready only in IDLE; a stalled response holds RESP and blocks new requests. Option: PQ_HOST_STATS_EN.
module pq_host_sequencer #(
    parameter int QUEUE_SIZE    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                            CLK,
    input  logic                            RSTn,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  logic [1:0]                      i_req_op,
    input  logic [DATA_WIDTH-1:0]           i_req_data,
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic [DATA_WIDTH-1:0]           o_rsp_data,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
    output logic                            o_full,
    output logic                            o_empty,
    output logic                            o_err,
    output logic                            o_pq_wrt,
    output logic                            o_pq_read,
    output logic [DATA_WIDTH-1:0]           o_pq_data,
    input  logic [DATA_WIDTH-1:0]           i_pq_data,
    output logic [15:0]                     o_stat_ops,
    output logic [15:0]                     o_stat_drops
);
    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] OP_ENQ = 2'b00;
    localparam logic [1:0] OP_DEQ = 2'b01;
    localparam logic [1:0] OP_REP = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_RESP} state_e;

    state_e                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rsp_q, rsp_d;
    logic [CW-1:0]         count_q, count_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic                  err_q, err_d;
    logic                  hs, illegal;

    assign o_full  = (count_q == CW'(QUEUE_SIZE));
    assign o_empty = (count_q == '0);
    assign hs      = i_req_valid & o_req_ready;
    assign illegal = (i_req_op == OP_BAD) ||
                     ((i_req_op == OP_ENQ) && o_full) ||
                     (((i_req_op == OP_DEQ) || (i_req_op == OP_REP)) && o_empty);

    // Queue pins are only ever driven during the single ISSUE cycle.
    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_data  = rsp_q;
    assign o_count     = count_q;
    assign o_err       = err_q;
    assign o_pq_wrt    = (state_q == ST_ISSUE) && ((op_q == OP_ENQ) || (op_q == OP_REP));
    assign o_pq_read   = (state_q == ST_ISSUE) && ((op_q == OP_DEQ) || (op_q == OP_REP));
    assign o_pq_data   = o_pq_wrt ? data_q : '0;

    // Next-state: request acceptance, issue, settle countdown, response hold.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        rsp_d    = rsp_q;
        count_d  = count_q;
        settle_d = settle_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = i_req_op;
                        data_d  = i_req_data;
                        // Top value before the op is exactly what DEQ/REPLACE removes.
                        rsp_d   = i_pq_data;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                settle_d = SW'(SETTLE_CYCLES - 1);
                state_d  = ST_SETTLE;
                if (op_q == OP_ENQ)      count_d = count_q + CW'(1);
                else if (op_q == OP_DEQ) count_d = count_q - CW'(1);
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = (op_q == OP_ENQ) ? ST_IDLE : ST_RESP;
                else                settle_d = settle_q - SW'(1);
            end
            ST_RESP: begin
                if (i_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers; reset aborts any op in flight.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ENQ;
            data_q   <= '0;
            rsp_q    <= '0;
            count_q  <= '0;
            settle_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            rsp_q    <= rsp_d;
            count_q  <= count_d;
            settle_q <= settle_d;
            err_q    <= err_d;
        end
    end

`ifdef PQ_HOST_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_drops_q, stat_drops_d;

    // Saturating event counters for issued ops and dropped requests.
    always_comb begin
        stat_ops_d   = stat_ops_q;
        stat_drops_d = stat_drops_q;
        if ((state_q == ST_ISSUE) && (stat_ops_q != 16'hFFFF)) stat_ops_d = stat_ops_q + 16'd1;
        if (err_q && (stat_drops_q != 16'hFFFF))               stat_drops_d = stat_drops_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stat_ops_q   <= '0;
            stat_drops_q <= '0;
        end else begin
            stat_ops_q   <= stat_ops_d;
            stat_drops_q <= stat_drops_d;
        end
    end

    assign o_stat_ops   = stat_ops_q;
    assign o_stat_drops = stat_drops_q;
`else
    assign o_stat_ops   = '0;
    assign o_stat_drops = '0;
`endif

endmodule

// File: tb/tb_pq_host_sequencer.sv
// Purpose: directed self-checking bench for pq_host_sequencer against a behavioural max-priority queue.
// Latency: checks exact pulse / settle / response timing at default SETTLE_CYCLES=4.
// Backpressure: holds i_rsp_ready low in RESP and checks the stall.
module tb_pq_host_sequencer;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [1:0]    i_req_op = 2'b00;
    logic [DW-1:0] i_req_data = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [DW-1:0] o_rsp_data;
    logic [3:0]    o_count;
    logic          o_full, o_empty, o_err, o_pq_wrt, o_pq_read;
    logic [DW-1:0] o_pq_data;
    logic [DW-1:0] pq_top = '0;
    logic [15:0]   o_stat_ops, o_stat_drops;

    int vectors = 0;
    int miscompares = 0;

    pq_host_sequencer dut (
        .CLK(CLK), .RSTn(RSTn),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_data(i_req_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_err(o_err),
        .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
        .i_pq_data(pq_top),
        .o_stat_ops(o_stat_ops), .o_stat_drops(o_stat_drops)
    );

    always #5 CLK = ~CLK;

    // Behavioural queue: top is the maximum stored key.
    logic [DW-1:0] mq [8];
    int            mn = 0;
    initial begin
        forever begin
            @(posedge CLK or negedge RSTn);
            if (!RSTn) begin
                mn = 0;
            end else begin
                if (o_pq_read && mn > 0) begin
                    int mi;
                    mi = 0;
                    for (int i = 1; i < mn; i++) if (mq[i] > mq[mi]) mi = i;
                    mq[mi] = mq[mn-1];
                    mn = mn - 1;
                end
                if (o_pq_wrt && mn < 8) begin
                    mq[mn] = o_pq_data;
                    mn = mn + 1;
                end
            end
            begin
                logic [DW-1:0] mx;
                mx = '0;
                for (int i = 0; i < mn; i++) if (mq[i] > mx) mx = mq[i];
                pq_top <= mx;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Handshake, check the ISSUE cycle, then the four quiet settle cycles (ends in T+5).
    task automatic issue(input logic [1:0] op, input logic [DW-1:0] d, input logic ew,
                         input logic er, input logic [DW-1:0] epd, input logic [3:0] ecnt);
        int pulses;
        i_req_valid = 1'b1; i_req_op = op; i_req_data = d;
        tick();
        i_req_valid = 1'b0;
        chk("issue_wrt", o_pq_wrt, ew);
        chk("issue_read", o_pq_read, er);
        chk("issue_data", o_pq_data, epd);
        chk("issue_ready", o_req_ready, 1'b0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) chk("count_after_issue", o_count, ecnt);
            pulses += int'(o_pq_wrt) + int'(o_pq_read) + int'(o_req_ready) + int'(o_pq_data != '0);
        end
        chk("settle_quiet", pulses, 0);
    endtask

    task automatic enq(input logic [DW-1:0] d, input logic [3:0] ecnt);
        issue(2'b00, d, 1'b1, 1'b0, d, ecnt);
        chk("enq_no_rsp", o_rsp_valid, 1'b0);
        tick();
        chk("enq_ready_T6", o_req_ready, 1'b1);
    endtask

    task automatic pop(input logic [1:0] op, input logic [DW-1:0] d, input logic ew,
                       input logic [DW-1:0] epd, input logic [3:0] ecnt,
                       input logic [DW-1:0] ersp, input int hold);
        issue(op, d, ew, 1'b1, epd, ecnt);
        chk("rsp_not_early", o_rsp_valid, 1'b0);
        tick();
        chk("rsp_valid_T6", o_rsp_valid, 1'b1);
        chk("rsp_data", o_rsp_data, ersp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_valid", o_rsp_valid, 1'b1);
            chk("bp_data_held", o_rsp_data, ersp);
            chk("bp_ready_low", o_req_ready, 1'b0);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        chk("rsp_done_ready", o_req_ready, 1'b1);
        chk("rsp_done_valid", o_rsp_valid, 1'b0);
    endtask

    task automatic bad(input logic [1:0] op, input logic [3:0] ecnt);
        i_req_valid = 1'b1; i_req_op = op; i_req_data = 32'hDEAD;
        tick();
        i_req_valid = 1'b0;
        chk("err_pulse", o_err, 1'b1);
        chk("err_no_pq", {o_pq_wrt, o_pq_read}, 2'b00);
        chk("err_ready", o_req_ready, 1'b1);
        chk("err_count", o_count, ecnt);
        tick();
        chk("err_one_cycle", o_err, 1'b0);
        chk("err_no_pq2", {o_pq_wrt, o_pq_read}, 2'b00);
    endtask

    initial begin
        // Reset state.
        tick(); tick();
        chk("rst_ready", o_req_ready, 1'b1);
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_full", o_full, 1'b0);
        chk("rst_count", o_count, 4'd0);
        chk("rst_outs", {o_rsp_valid, o_err, o_pq_wrt, o_pq_read}, 4'b0000);
        chk("rst_rsp_data", o_rsp_data, 32'd0);
        chk("rst_stats", {o_stat_ops, o_stat_drops}, 32'd0);
        RSTn = 1'b1;
        tick();

        // ENQ 5, 9, 3.
        enq(32'd5, 4'd1);
        enq(32'd9, 4'd2);
        enq(32'd3, 4'd3);

        // DEQ top 9 with 10 cycles of response backpressure.
        pop(2'b01, 32'd0, 1'b0, 32'd0, 4'd2, 32'd9, 10);
        // REPLACE key 7, top 5.
        pop(2'b10, 32'd7, 1'b1, 32'd7, 4'd2, 32'd5, 0);
        // Drain: queue holds {3,7}.
        pop(2'b01, 32'd0, 1'b0, 32'd0, 4'd1, 32'd7, 0);
        pop(2'b01, 32'd0, 1'b0, 32'd0, 4'd0, 32'd3, 0);
        chk("empty_flag", o_empty, 1'b1);

        // Illegal ops: DEQ when empty, ENQ when full, op 11.
        bad(2'b01, 4'd0);
        for (int i = 0; i < 8; i++) enq(32'(10 + i), 4'(i + 1));
        chk("full_flag", o_full, 1'b1);
        bad(2'b00, 4'd8);
        bad(2'b11, 4'd8);

`ifdef PQ_HOST_STATS_EN
        chk("stat_ops", o_stat_ops, 16'd15);
        chk("stat_drops", o_stat_drops, 16'd3);
`else
        chk("stat_ops_off", o_stat_ops, 16'd0);
        chk("stat_drops_off", o_stat_drops, 16'd0);
`endif

        // Reset in the middle of SETTLE after a DEQ.
        i_req_valid = 1'b1; i_req_op = 2'b01;
        tick();
        i_req_valid = 1'b0;
        tick(); tick();
        RSTn = 1'b0;
        #1;
        chk("midrst_count", o_count, 4'd0);
        chk("midrst_empty", o_empty, 1'b1);
        chk("midrst_ready", o_req_ready, 1'b1);
        chk("midrst_pq", {o_pq_wrt, o_pq_read, |o_pq_data}, 3'b000);
        chk("midrst_stats", {o_stat_ops, o_stat_drops}, 32'd0);
        tick();
        RSTn = 1'b1;
        tick();
        enq(32'd4, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
